// File: rtl/pipeline_fork.sv
// Registered one-to-N fork: one upstream word held in a register and delivered
// exactly once to each of N independently handshaking branches.
module pipeline_fork #(
    parameter int unsigned N  = 2,
    parameter int unsigned DW = 256
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          i_valid,
    output logic          i_ready,
    input  logic [DW-1:0] i_data,
    output logic [N-1:0]  o_valid,
    input  logic [N-1:0]  o_ready,
    output logic [DW-1:0] o_data
);

    logic [N-1:0]  pending;
    logic [N-1:0]  done;
    logic [N-1:0]  remain;
    logic [DW-1:0] data_r;

    always_comb begin
        done    = pending & o_ready;
        remain  = pending & ~done;
        i_ready = (remain == '0);
    end

    // A load overrides the clearing of pending bits so the last takers and a
    // new word can share one cycle without a bubble.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pending <= '0;
            data_r  <= '0;
        end else if (i_valid && i_ready) begin
            pending <= '1;
            data_r  <= i_data;
        end else begin
            pending <= remain;
        end
    end

    assign o_valid = pending;
    assign o_data  = data_r;

endmodule

// File: doc/pipeline_fork.md
# pipeline_fork

Registered one-to-N fork stage. Accepts a data word over a single valid/ready pair, holds it in an output register, and presents it to N independent consumers, each with its own valid/ready pair. Each branch handshakes at its own pace, and a branch never sees the same word twice. It is the counterpart of the N-to-1 combine stage: it fans an operand out to parallel datapath units (e.g. Montgomery multiplier lanes) whose results are later joined back into one handshake.

## Interface
- `N`, default 2: number of output branches, at least 1.
- `DW`, default 256: data width in bits.

- `clk` in 1: clock; all state updates on the rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `i_valid` in 1: upstream word valid.
- `i_ready` out 1: stage accepts the word this cycle.
- `i_data` in DW: upstream word.
- `o_valid [N]` out 1 each: branch k holds a word it has not yet taken.
- `o_ready [N]` in 1 each: branch k accepts this cycle.
- `o_data` out DW: registered word, shared by all branches.

## Operation
- State:
  - `data_r` [DW]: the held word.
  - `pending` [N]: one bit per branch that still has to take `data_r`.
- Outputs:
  - `o_valid[k] = pending[k]`, purely registered.
  - `o_data = data_r`.
- `done[k] = pending[k] & o_ready[k]`.
- `remain = pending & ~done`.
- `i_ready = (remain == 0)`. The stage is free when nothing is pending, or when every still-pending branch completes this cycle.
- Combinational path: `i_ready` depends combinationally on `o_ready`. It has no combinational path from `i_valid` or `i_data`.
- Load (`i_valid & i_ready`):
  - `data_r <= i_data`.
  - `pending <= all ones`.
- Otherwise:
  - `pending <= remain`.
  - `data_r` holds.
- Invariants:
  - `data_r` never changes while any bit of `pending` is set, unless the load condition holds in the same cycle.
  - Each loaded word is delivered exactly once per branch.
  - A branch that completes early keeps its `o_valid` low until the next load.
- Branch with `o_ready` high while `o_valid` is low: ignored, no effect.
- `i_valid` low: no state change other than `pending` clearing bits.
- `N = 1`: behaves as a full-throughput forward-registered slice.

## Timing
- Reset, asynchronous and effective immediately:
  - `pending = 0`, so all `o_valid` are 0.
  - `data_r = 0`, so `o_data` is 0.
  - `i_ready = 1` while `rst_n` is low.
- Latency: a word accepted at edge t appears with `o_valid[*] = 1` in the cycle after edge t.
- Throughput: one word per cycle when all `o_ready` are held high.
- Simultaneous events:
  - The last pending branches complete in the same cycle as a new input arrives: the new word loads in that cycle with no bubble.
  - In that case `pending` goes to all ones, not to `remain`.
- Partial completion: branches completing in cycle c see `o_valid` low from cycle c+1. The other branches keep `o_valid` high with unchanged `o_data`.
- Stall: with any branch stalled, `i_ready` stays low and upstream must hold `i_valid` and `i_data`.
- Reset mid-operation:
  - The held word and all pending deliveries are discarded.
  - No `o_valid` pulse appears after reset release until a new load.
- Upstream protocol: `i_valid` must not drop before it is accepted. A bench assertion flags any violation.

## Test plan
- **Reset.** Assert `rst_n = 0` mid-transfer with `pending = 2'b11`. Required: `o_valid = {0,0}`, `o_data = 0` and `i_ready = 1` immediately, before any clock edge.
- **Single word, N=2.** Send `i_data = 0x1234` with both `o_ready` high. Required: `i_ready = 1` at accept; the next cycle shows `o_valid = {1,1}`, `o_data = 0x1234`; the cycle after shows `o_valid = {0,0}`.
- **Skewed branches.**
  - Stimulus: load `0xAA`; `o_ready[0] = 1` in cycle 1; `o_ready[1]` held low until cycle 4; `i_valid` high with `0xBB` throughout.
  - Required: `o_valid[0]` drops in cycle 2 and `o_valid[1]` stays high until it is taken in cycle 4.
  - Required: `i_ready` is low in cycles 1–3 and high in cycle 4; `0xBB` loads at cycle 4 and appears on both branches in cycle 5; `0xAA` is delivered once per branch.
- **Back-to-back.** Stream 8 words `0..7` with all `o_ready` high. Required: one word per cycle, no bubbles, and each branch receives exactly `0..7` in order.
- **Random stress.** N=4 with random `i_valid` and `o_ready` (50%) over 10k cycles. Required:
  - A scoreboard per branch matches the input order, with no duplicates and no losses.
  - `o_data` is stable while any `o_valid` is high and unaccepted.
- **Idle ready.** Pulse `o_ready = 1` with `pending = 0`. Required: no state change, and `o_valid` stays 0.
